// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Shared constants and types for the CORDIC pipeline. The rotation stage
// also uses the Q2.14 sample type, so this package is not specific to the
// gain-compensation stage.
//   WIDTH    : sample width (signed Q2.14)
//   K_CONST  : gain correction K = 0.6072529 as unsigned Q1.15
//   FRAC     : fractional bits of K_CONST (product is shifted right by FRAC)
//   ACC_W    : width of the signed product accumulator
//   IDX_W    : width of the iteration index (one iteration per K_CONST bit)
//   IDX_LAST : value of the iteration index on the final iteration
//   ROUND_C  : round-half-up constant 2^(FRAC-1), added before the shift
// ---------------------------------------------------------------------------
package cordic_pkg;

    localparam int WIDTH = 16;
    localparam int FRAC  = 15;
    localparam int ACC_W = 2 * WIDTH;
    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] K_CONST = 16'h4DBA;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    localparam logic signed [ACC_W-1:0] ROUND_C =
        {{(ACC_W - 1){1'b0}}, 1'b1} << (FRAC - 1);

    // Signed Q2.14 sample.
    typedef logic signed [WIDTH-1:0] sample_t;

    // Controller states of the gain-compensation stage.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : cordic_pkg

// File: rtl/cordic_gain_comp_if.sv
// ---------------------------------------------------------------------------
// cordic_gain_comp_if
// Sample in/out bundle of the gain-compensation stage.
//   data_in_valid : one-cycle input strobe (data_out_rot of the rotation stage)
//   xprime/yprime : uncorrected coordinates, valid with data_in_valid
//   data_out_comp : one-cycle output strobe, xcomp/ycomp hold a new result
//   xcomp/ycomp   : gain-corrected coordinates
//   busy          : stage is multiplying or presenting a result
//   overflow      : sticky flag, a sample was dropped
// The master modport is the upstream/observer side; the slave modport is the
// compensation stage itself.
// ---------------------------------------------------------------------------
interface cordic_gain_comp_if;
    import cordic_pkg::*;

    logic    data_in_valid;
    sample_t xprime;
    sample_t yprime;
    logic    data_out_comp;
    sample_t xcomp;
    sample_t ycomp;
    logic    busy;
    logic    overflow;

    modport master (
        output data_in_valid,
        output xprime,
        output yprime,
        input  data_out_comp,
        input  xcomp,
        input  ycomp,
        input  busy,
        input  overflow
    );

    modport slave (
        input  data_in_valid,
        input  xprime,
        input  yprime,
        output data_out_comp,
        output xcomp,
        output ycomp,
        output busy,
        output overflow
    );

endinterface : cordic_gain_comp_if

// File: rtl/gain_shift_add_mul.sv
// ---------------------------------------------------------------------------
// gain_shift_add_mul
// Single-channel iterative multiply by K_CONST. One K_CONST bit is consumed
// per step: when bit step_idx is set, the sign-extended operand shifted left
// by step_idx is added to the accumulator. On the last step the rounded,
// arithmetically shifted result is registered onto 'result', where it stays
// until the next last step.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_val as the operand and clear the accumulator
//   load_val   : operand to capture
//   step       : perform one shift-add iteration for bit step_idx
//   last       : this step is the final one; register the rounded result
//   step_idx   : K_CONST bit handled by this step
//   result     : registered gain-corrected value
// ---------------------------------------------------------------------------
module gain_shift_add_mul
    import cordic_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  sample_t          load_val,
    input  logic             step,
    input  logic             last,
    input  logic [IDX_W-1:0] step_idx,
    output sample_t          result
);

    sample_t                 v_r;
    sample_t                 result_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] v_ext_s;
    logic signed [ACC_W-1:0] addend_s;
    logic signed [ACC_W-1:0] acc_next_s;
    sample_t                 result_next_s;

    // Partial product for the current K bit, next accumulator and rounded result.
    always_comb begin
        v_ext_s = {{WIDTH{v_r[WIDTH-1]}}, v_r};
        if (K_CONST[step_idx]) begin
            addend_s = v_ext_s << step_idx;
        end else begin
            addend_s = '0;
        end
        acc_next_s = acc_r + addend_s;
        // Truncation to WIDTH bits is safe: K < 1 keeps |result| <= |v|.
        result_next_s = sample_t'((acc_next_s + ROUND_C) >>> FRAC);
    end

    // Operand, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r      <= '0;
            acc_r    <= '0;
            result_r <= '0;
        end else begin
            if (load) begin
                v_r   <= load_val;
                acc_r <= '0;
            end else if (step) begin
                acc_r <= acc_next_s;
            end
            if (step && last) begin
                result_r <= result_next_s;
            end
        end
    end

    assign result = result_r;

endmodule : gain_shift_add_mul

// File: rtl/cordic_gain_comp.sv
// ---------------------------------------------------------------------------
// cordic_gain_comp
// Gain-correction stage after the rotation CORDIC. Each strobed (xprime,
// yprime) pair is multiplied by K = 0.6072529 with two parallel shift-add
// multipliers (16 iterations), rounded half-up and presented on xcomp/ycomp
// with a one-cycle data_out_comp strobe, 17 cycles after the input strobe.
// A one-entry holding buffer absorbs a sample arriving mid-multiply; a sample
// arriving while the buffer is full during MUL is dropped and sets the
// sticky overflow flag.
//   Clk   : system clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : sample in/out bundle (slave side)
// ---------------------------------------------------------------------------
module cordic_gain_comp
    import cordic_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    cordic_gain_comp_if.slave bus
);

    state_t           state_r;
    state_t           state_next_s;
    logic [IDX_W-1:0] idx_r;
    logic             buf_full_r;
    sample_t          buf_x_r;
    sample_t          buf_y_r;
    logic             overflow_r;
    logic             busy_r;
    logic             strobe_r;

    logic             load_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic             step_s;
    logic             last_s;
    sample_t          load_x_s;
    sample_t          load_y_s;
    sample_t          xcomp_s;
    sample_t          ycomp_s;

    // Next-state logic plus multiplier load source and buffer push/pop/drop.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        drop_s       = 1'b0;
        load_x_s     = bus.xprime;
        load_y_s     = bus.yprime;
        step_s       = (state_r == MUL);
        last_s       = (state_r == MUL) && (idx_r == IDX_LAST);

        case (state_r)
            IDLE: begin
                if (bus.data_in_valid) begin
                    load_s       = 1'b1;
                    state_next_s = MUL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                if (idx_r == IDX_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = MUL;
                end
                if (bus.data_in_valid) begin
                    if (buf_full_r) begin
                        drop_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end else begin
                    push_s = 1'b0;
                end
            end
            DONE: begin
                if (buf_full_r) begin
                    // Buffered sample goes first; a simultaneous new input
                    // takes its place in the buffer.
                    load_s       = 1'b1;
                    load_x_s     = buf_x_r;
                    load_y_s     = buf_y_r;
                    pop_s        = 1'b1;
                    push_s       = bus.data_in_valid;
                    state_next_s = MUL;
                end else if (bus.data_in_valid) begin
                    load_s       = 1'b1;
                    state_next_s = MUL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Iteration index: restarts on every load, advances once per MUL cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            idx_r <= '0;
        end else if (load_s) begin
            idx_r <= '0;
        end else if (step_s) begin
            idx_r <= idx_r + {{(IDX_W - 1){1'b0}}, 1'b1};
        end
    end

    // One-entry holding buffer; push wins over pop so pop+push keeps it full.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            buf_full_r <= 1'b0;
            buf_x_r    <= '0;
            buf_y_r    <= '0;
        end else if (push_s) begin
            buf_full_r <= 1'b1;
            buf_x_r    <= bus.xprime;
            buf_y_r    <= bus.yprime;
        end else if (pop_s) begin
            buf_full_r <= 1'b0;
        end
    end

    // Registered status outputs: busy, result strobe and sticky overflow.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            busy_r     <= 1'b0;
            strobe_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            busy_r     <= (state_next_s != IDLE);
            strobe_r   <= (state_next_s == DONE);
            overflow_r <= overflow_r | drop_s;
        end
    end

    gain_shift_add_mul u_mul_x (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (load_s),
        .load_val (load_x_s),
        .step     (step_s),
        .last     (last_s),
        .step_idx (idx_r),
        .result   (xcomp_s)
    );

    gain_shift_add_mul u_mul_y (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (load_s),
        .load_val (load_y_s),
        .step     (step_s),
        .last     (last_s),
        .step_idx (idx_r),
        .result   (ycomp_s)
    );

    assign bus.xcomp         = xcomp_s;
    assign bus.ycomp         = ycomp_s;
    assign bus.data_out_comp = strobe_r;
    assign bus.busy          = busy_r;
    assign bus.overflow      = overflow_r;

endmodule : cordic_gain_comp

// File: doc/cordic_gain_comp.md
Name: cordic_gain_comp

Overview:
Downstream stage of the rotation CORDIC. It consumes each (xprime, yprime) result, marked by the one-cycle data_out_rot strobe. It multiplies both values by the CORDIC gain correction K = 0.6072529 and delivers gain-corrected coordinates with its own strobe. A sequential shift-add multiplier processes x and y in parallel. A one-entry holding buffer absorbs a result that arrives while a multiply is in progress.

Parameters:
WIDTH, 16, data width of x/y in and out (signed Q2.14)
K_CONST, 19898 (0x4DBA), gain correction, unsigned Q1.15
FRAC, 15, fractional bits of K_CONST (result shift)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
data_in_valid  input  1  one-cycle strobe, driven by data_out_rot of the rotation stage
xprime  input  WIDTH  signed uncorrected x, valid with strobe
yprime  input  WIDTH  signed uncorrected y, valid with strobe
data_out_comp  output  1  one-cycle strobe: xcomp/ycomp hold a new result
xcomp  output  WIDTH  signed corrected x
ycomp  output  WIDTH  signed corrected y
busy  output  1  high while in MUL or DONE
overflow  output  1  sticky: a sample was dropped

Behaviour:
- Reset (Reset=0, async): state=IDLE; data_out_comp=0, xcomp=0, ycomp=0, busy=0, overflow=0; holding buffer empty.
- Reset mid-operation aborts the multiply and discards buffer contents. No strobe is produced for the aborted sample.
- Arithmetic, per channel: result = (v * K_CONST + 2^(FRAC-1)) >>> FRAC.
  - v is signed WIDTH bits; the product is a signed 2*WIDTH accumulator.
  - Rounding is round-half-up; the shift is arithmetic.
  - Result is truncated to WIDTH bits. No saturation is needed because K < 1.
  - Output must be bit-exact to this formula.
- Multiply method: 16 iterations, one per K_CONST bit (i = 0..15). If bit i is set, acc += v << i. The rounding constant is added in the DONE transition.
- FSM:
  - IDLE: busy=0. If data_in_valid at edge E0, capture xprime/yprime and clear acc; go to MUL with i=0.
  - MUL: one iteration per edge. After the iteration with i=15 (edge E16), go to DONE.
  - DONE: xcomp/ycomp are registered on entry. data_out_comp=1 for exactly this one cycle. Outputs hold until the next DONE.
  - Leaving DONE:
    - Buffer full: load buffer into MUL and empty the buffer.
    - Else, data_in_valid: load the input into MUL.
    - Else: go to IDLE.
- Latency: input strobe sampled at edge E0; data_out_comp is high in the cycle after E16 (17 cycles). Back-to-back throughput is one sample per 17 cycles.
- Holding buffer (one entry):
  - data_in_valid while busy, buffer empty, and not already consumed directly by DONE→MUL: store in buffer.
  - data_in_valid in DONE with buffer full: buffer goes to MUL and the new input goes into the buffer (simultaneous pop/push; no drop).
  - data_in_valid while in MUL with buffer full: sample is dropped and overflow is set to 1. overflow stays set until reset.
- data_in_valid held high for several cycles is treated as several samples.

Decomposition:
- Package cordic_pkg:
  - WIDTH and K_CONST/FRAC constants.
  - typedef of the signed Q2.14 sample.
  - FSM state enum {IDLE, MUL, DONE}.
  - The same Q2.14 type is shared with the rotation stage.
- One natural sub-module, gain_shift_add_mul: a single-channel iterative accumulator (load, step, round/output), instantiated twice for x and y. The FSM and holding buffer stay in the top.

Test Plan:
- Reset then strobe x=0x4000, y=0xC000 → 17 cycles later data_out_comp=1 for one cycle, xcomp=0x26DD (9949), ycomp=0xD923 (-9949); busy low afterwards.
- Extremes x=0x7FFF, y=0x8000 → xcomp=0x4DB9 (19897, rounding check), ycomp=0xB246 (-19898); x=y=0 → 0x0000/0x0000.
- Second strobe 5 cycles after the first (buffered) → two strobes 17 cycles apart, correct values in order, overflow=0.
- Three strobes in cycles 0, 2, 4 → third dropped, overflow=1 and stays 1; exactly two output strobes.
- Strobe exactly in the DONE cycle with buffer full → buffered sample then the new sample both emitted, 17 cycles apart, no overflow.
- Assert Reset low at iteration 8 → all outputs 0 immediately (asynchronously); no strobe; a fresh sample afterwards produces the correct result after 17 cycles.
